pc_sequencer: RTL

- Program-counter sequencer for the fetch stage: a parametrised successor to the fixed +2 incrementer.
- Holds the PC register and advances it by a configurable STEP, wrapping modulo 2^WIDTH.
- Handles fetch back-pressure, branch/jump redirects, call/return through an internal return-address stack (RAS), and halt.
- Sits between the decode/execute redirect logic and the instruction-memory address port.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_sequencer shared types: sequencer states, default parameters and
// the step-alignment helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } seq_state_t;

    localparam int          DEFAULT_WIDTH     = 16;
    localparam int          DEFAULT_STEP      = 2;
    localparam logic [15:0] DEFAULT_RESET_VEC = 16'h0000;

    function automatic int clog2_step(input int step);
        int k;
        k = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < step) k = i + 1;
        end
        return k;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow leaves the stack untouched; both pulse err for one cycle.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_next;
    logic [PW-1:0]    sp_prev;
    logic [CW-1:0]    cnt;

    // sp is the next free slot; when full it also addresses the oldest entry
    assign sp_next = (sp == LAST) ? '0 : sp + PW'(1);
    assign sp_prev = (sp == '0) ? LAST : sp - PW'(1);
    assign top     = mem[sp_prev];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            if (push) begin
                sp <= sp_next;
                if (full) err <= 1'b1;
                else      cnt <= cnt + CW'(1);
            end else if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    sp  <= sp_prev;
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[sp] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer with redirect, call/return RAS and halt.
// Optional redirect alignment check: define PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               STEP      = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_err,
    output logic             halted
`ifdef PC_SEQ_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    localparam int K = clog2_step(STEP);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << K) - 1);

    seq_state_t       state;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] ras_top;
    logic             redir_ok;
    logic             run_live;
    logic             do_push;
    logic             do_pop;
    logic             ras_full_unused;

    assign pc_inc = pc + WIDTH'(STEP);

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic bad_tgt;
    assign bad_tgt  = redir_valid && ((redir_target & LOW_MASK) != '0);
    assign redir_ok = redir_valid && !bad_tgt;
    assign tgt      = redir_target;
`else
    assign redir_ok = redir_valid;
    assign tgt      = redir_target & ~LOW_MASK;
`endif

    assign run_live = (state == RUN) && !halt;
    assign do_push  = run_live && redir_ok && call;
    assign do_pop   = run_live && !redir_ok && ret;

    pc_ras #(
        .WIDTH    (WIDTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (do_push),
        .pop  (do_pop),
        .din  (pc_inc),
        .top  (ras_top),
        .empty(ras_empty),
        .full (ras_full_unused),
        .err  (ras_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign <= 1'b0;
`endif
        end else begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign <= run_live && bad_tgt;
`endif
            unique case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (redir_ok) begin
                        pc <= tgt;
                    end else if (ret) begin
                        // empty stack: fall through sequentially
                        pc <= ras_empty ? pc_inc : ras_top;
                    end else if (fetch_ready) begin
                        pc <= pc_inc;
                    end
                end
                HALT: begin
                    pc_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
